// File: rtl/barrel_shift_pipe_if.sv
// Operand/result handshake bundle for the pipelined barrel shifter.
// The master side offers operations and consumes results; the slave side is the shifter.
interface barrel_shift_pipe_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [15:0]      rfread;
    logic [1:0]       in_mode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_carry;
    logic             out_zero;

    modport master (
        output in_valid, in_data, rfread, in_mode, out_ready,
        input  in_ready, out_valid, out_data, out_carry, out_zero
    );

    modport slave (
        input  in_valid, in_data, rfread, in_mode, out_ready,
        output in_ready, out_valid, out_data, out_carry, out_zero
    );
endinterface

// File: rtl/barrel_shift_pipe.sv
// Pipelined barrel shifter: LSL / LSR / ASR / ROR with carry-out and zero flags.
// One log-shift stage per amount bit, a globally stalled valid/ready pipeline,
// results in strict FIFO order.
module barrel_shift_pipe #(
    parameter int WIDTH = 16
) (
    input logic               clk,
    input logic               reset,
    barrel_shift_pipe_if.slave bus
);
    localparam int SHW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        MODE_LSL = 2'b00,
        MODE_LSR = 2'b01,
        MODE_ASR = 2'b10,
        MODE_ROR = 2'b11
    } mode_e;

    logic             adv;
    logic             cap_valid;
    logic [WIDTH-1:0] cap_data;
    mode_e            cap_mode;
    logic [SHW-1:0]   cap_amt;
    logic             unused_bits;

    // Whole pipeline advances unless a finished result is waiting on the consumer.
    assign adv          = !g_stage[SHW-1].valid_q || bus.out_ready;
    assign bus.in_ready = adv;

    // Operand capture rank: holds the raw operation ahead of the first shift stage,
    // giving an accept-to-result latency of SHW edges.
    always_ff @(posedge clk) begin
        if (reset) begin
            cap_valid <= 1'b0;
            cap_data  <= '0;
            cap_mode  <= MODE_LSL;
            cap_amt   <= '0;
        end else if (adv) begin
            cap_valid <= bus.in_valid;
            cap_data  <= bus.in_data;
            cap_mode  <= mode_e'(bus.in_mode);
            cap_amt   <= bus.rfread[SHW-1:0];
        end
    end

    for (genvar k = 0; k < SHW; k++) begin : g_stage
        localparam int SH = 1 << k;

        logic [WIDTH-1:0] d;
        logic             c;
        mode_e            m;
        logic [SHW-1:0]   a;
        logic             v;
        logic [WIDTH-1:0] r;
        logic             rc;

        logic             valid_q;
        logic [WIDTH-1:0] data_q;
        logic             carry_q;
        mode_e            mode_q;
        logic [SHW-1:0]   amt_q;

        if (k == 0) begin : g_first
            assign d = cap_data;
            assign c = 1'b0;
            assign m = cap_mode;
            assign a = cap_amt;
            assign v = cap_valid;
        end else begin : g_rest
            assign d = g_stage[k-1].data_q;
            assign c = g_stage[k-1].carry_q;
            assign m = g_stage[k-1].mode_q;
            assign a = g_stage[k-1].amt_q;
            assign v = g_stage[k-1].valid_q;
        end

        // Shift by 2^k when this stage's amount bit is set; otherwise pass data and carry.
        always_comb begin
            r  = d;
            rc = c;
            if (a[0]) begin
                case (m)
                    MODE_LSL: begin
                        r  = d << SH;
                        rc = d[WIDTH-SH];
                    end
                    MODE_LSR: begin
                        r  = d >> SH;
                        rc = d[SH-1];
                    end
                    MODE_ASR: begin
                        r  = WIDTH'($signed(d) >>> SH);
                        rc = d[SH-1];
                    end
                    MODE_ROR: begin
                        r  = (d >> SH) | (d << (WIDTH - SH));
                        rc = r[WIDTH-1];
                    end
                endcase
            end
        end

        // Stage register; the remaining amount is shifted down so bit 0 always
        // belongs to the next stage.
        always_ff @(posedge clk) begin
            if (reset) begin
                valid_q <= 1'b0;
                data_q  <= '0;
                carry_q <= 1'b0;
                mode_q  <= MODE_LSL;
                amt_q   <= '0;
            end else if (adv) begin
                valid_q <= v;
                data_q  <= r;
                carry_q <= rc;
                mode_q  <= m;
                amt_q   <= a >> 1;
            end
        end
    end

    assign bus.out_valid = g_stage[SHW-1].valid_q;
    assign bus.out_data  = g_stage[SHW-1].data_q;
    assign bus.out_carry = g_stage[SHW-1].carry_q;
    assign bus.out_zero  = (g_stage[SHW-1].data_q == '0);

    // Upper rfread bits and the last stage's forwarded control fields have no consumer.
    assign unused_bits = &{1'b0, bus.rfread[15:SHW], g_stage[SHW-1].mode_q, g_stage[SHW-1].amt_q};
endmodule

// File: tb/tb_barrel_shift_pipe.sv
// Bench for barrel_shift_pipe: directed vector table, backpressure and reset
// sequences, then randomized traffic against a net-result reference model.
module tb_barrel_shift_pipe;
    localparam int W   = 16;
    localparam int SHW = $clog2(W);

    logic clk   = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    barrel_shift_pipe_if #(.WIDTH(W)) bus ();

    barrel_shift_pipe #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [1:0]   mode;
        logic [W-1:0] data;
        logic [15:0]  rf;
        logic [W-1:0] exp_d;
        logic         exp_c;
        logic         exp_z;
    } vec_t;

    vec_t vecs [13];

    logic [W:0]   exp_q [$];
    logic [W:0]   exp_e;
    logic         hold_pend = 1'b0;
    logic [W-1:0] hold_d;
    logic         hold_c;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        failures++;
        $display("FAIL %s: bound expired", name);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Net shift result from the architectural rules: {carry, data}.
    function automatic logic [W:0] model(input logic [W-1:0] d, input logic [15:0] rf,
                                         input logic [1:0] m);
        int unsigned  amt;
        logic [W-1:0] r;
        logic         c;
        amt = rf % W;
        r   = d;
        c   = 1'b0;
        if (amt != 0) begin
            case (m)
                2'd0: begin r = d << amt; c = d[W-amt]; end
                2'd1: begin r = d >> amt; c = d[amt-1]; end
                2'd2: begin r = W'($signed(d) >>> amt); c = d[amt-1]; end
                default: begin r = (d >> amt) | (d << (W - amt)); c = r[W-1]; end
            endcase
        end
        return {c, r};
    endfunction

    // Scoreboard: record accepted ops, compare delivered results in order,
    // and confirm a stalled result does not change.
    always @(negedge clk) begin
        if (reset) begin
            exp_q.delete();
            hold_pend = 1'b0;
        end else begin
            check("in_ready_rule", 32'(bus.in_ready), 32'(!bus.out_valid || bus.out_ready));
            if (hold_pend) begin
                check("hold_valid", 32'(bus.out_valid), 32'd1);
                check("hold_data", {15'd0, bus.out_carry, bus.out_data}, {15'd0, hold_c, hold_d});
            end
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL sb_unexpected: got 0x%0h expected no result", bus.out_data);
                end else begin
                    exp_e = exp_q.pop_front();
                    check("sb_data", 32'(bus.out_data), 32'(exp_e[W-1:0]));
                    check("sb_carry", 32'(bus.out_carry), 32'(exp_e[W]));
                    check("sb_zero", 32'(bus.out_zero), 32'(exp_e[W-1:0] == '0));
                end
            end
            hold_pend = bus.out_valid && !bus.out_ready;
            hold_d    = bus.out_data;
            hold_c    = bus.out_carry;
            if (bus.in_valid && bus.in_ready)
                exp_q.push_back(model(bus.in_data, bus.rfread, bus.in_mode));
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic run_one(input vec_t v, input string tag);
        int lat;
        bus.in_valid = 1'b1;
        bus.in_data  = v.data;
        bus.rfread   = v.rf;
        bus.in_mode  = v.mode;
        check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
        step();
        bus.in_valid = 1'b0;
        lat = 0;
        while (!bus.out_valid && lat < 20) begin
            step();
            lat++;
        end
        if (!bus.out_valid) begin
            fail({tag, "_timeout"});
        end else begin
            check({tag, "_latency"}, 32'(lat), 32'(SHW));
            check({tag, "_data"}, 32'(bus.out_data), 32'(v.exp_d));
            check({tag, "_carry"}, 32'(bus.out_carry), 32'(v.exp_c));
            check({tag, "_zero"}, 32'(bus.out_zero), 32'(v.exp_z));
        end
    endtask

    initial begin
        int  next_op, got, stall_left, cyc, last_cyc, seen;
        logic first_seen, acc;

        vecs[0]  = '{2'd1, 16'hF0F0, 16'h0004, 16'h0F0F, 1'b0, 1'b0};
        vecs[1]  = '{2'd2, 16'h8001, 16'h0001, 16'hC000, 1'b1, 1'b0};
        vecs[2]  = '{2'd1, 16'h8001, 16'h0001, 16'h4000, 1'b1, 1'b0};
        vecs[3]  = '{2'd0, 16'h8001, 16'h00F1, 16'h0002, 1'b1, 1'b0};
        vecs[4]  = '{2'd0, 16'h8000, 16'h0001, 16'h0000, 1'b1, 1'b1};
        vecs[5]  = '{2'd3, 16'h0001, 16'h000F, 16'h0002, 1'b0, 1'b0};
        vecs[6]  = '{2'd3, 16'h0003, 16'h0001, 16'h8001, 1'b1, 1'b0};
        vecs[7]  = '{2'd0, 16'h1234, 16'h0010, 16'h1234, 1'b0, 1'b0};
        vecs[8]  = '{2'd2, 16'hABCD, 16'h0010, 16'hABCD, 1'b0, 1'b0};
        vecs[9]  = '{2'd3, 16'h00FF, 16'h0010, 16'h00FF, 1'b0, 1'b0};
        vecs[10] = '{2'd1, 16'h0000, 16'h0003, 16'h0000, 1'b0, 1'b1};
        vecs[11] = '{2'd0, 16'h0001, 16'h000F, 16'h8000, 1'b0, 1'b0};
        vecs[12] = '{2'd2, 16'h8000, 16'h000F, 16'hFFFF, 1'b0, 1'b0};

        // Reset state, with an operation offered during reset that must be ignored.
        bus.in_valid  = 1'b1;
        bus.in_data   = 16'hFFFF;
        bus.rfread    = 16'h0001;
        bus.in_mode   = 2'd0;
        bus.out_ready = 1'b1;
        repeat (3) step();
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_data", 32'(bus.out_data), 32'd0);
        check("rst_out_carry", 32'(bus.out_carry), 32'd0);
        check("rst_out_zero", 32'(bus.out_zero), 32'd1);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        reset        = 1'b0;
        bus.in_valid = 1'b0;
        step();
        check("rel_out_valid", 32'(bus.out_valid), 32'd0);
        check("rel_out_data", 32'(bus.out_data), 32'd0);
        check("rel_out_zero", 32'(bus.out_zero), 32'd1);
        check("rel_in_ready", 32'(bus.in_ready), 32'd1);
        seen = 0;
        for (int i = 0; i < SHW + 2; i++) begin
            step();
            if (bus.out_valid) seen++;
        end
        check("rst_offer_dropped", 32'(seen), 32'd0);

        // Directed vector table, one operation at a time.
        for (int i = 0; i < 13; i++) run_one(vecs[i], $sformatf("vec%0d", i));
        step();

        // Backpressure: six LSL-by-1 ops, consumer stalls 3 cycles at the first result.
        bus.in_mode  = 2'd0;
        bus.rfread   = 16'h0001;
        bus.in_data  = 16'd1;
        bus.in_valid = 1'b1;
        next_op = 1; got = 0; stall_left = 0; cyc = 0; last_cyc = 0; first_seen = 1'b0;
        while (got < 6 && cyc < 60) begin
            @(negedge clk);
            if (!bus.out_ready) begin
                check("bp_in_ready_stall", 32'(bus.in_ready), 32'd0);
                check("bp_hold_0002", 32'(bus.out_data), 32'd2);
            end
            if (bus.out_valid && bus.out_ready) begin
                check("bp_data", 32'(bus.out_data), 32'(2 * (got + 1)));
                if (got > 0) check("bp_no_gap", 32'(cyc), 32'(last_cyc + 1));
                last_cyc = cyc;
                got++;
            end
            acc = bus.in_valid && bus.in_ready;
            step();
            cyc++;
            if (acc) next_op++;
            if (next_op <= 6) bus.in_data = 16'(next_op);
            else bus.in_valid = 1'b0;
            if (bus.out_valid && !first_seen) begin
                first_seen = 1'b1;
                stall_left = 3;
            end
            if (stall_left > 0) begin
                bus.out_ready = 1'b0;
                stall_left--;
            end else begin
                bus.out_ready = 1'b1;
            end
        end
        if (got < 6) fail("bp_delivery");
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (2) step();

        // Reset while three operations are in flight.
        bus.in_mode = 2'd1;
        bus.rfread  = 16'h0002;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.in_data = 16'h1000 + 16'(i);
            step();
        end
        bus.in_valid = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("mid_rst_out_data", 32'(bus.out_data), 32'd0);
        check("mid_rst_out_zero", 32'(bus.out_zero), 32'd1);
        check("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
        seen = 0;
        for (int i = 0; i < SHW + 2; i++) begin
            step();
            if (bus.out_valid) seen++;
        end
        check("mid_rst_no_stale", 32'(seen), 32'd0);
        run_one(vecs[0], "post_rst");
        step();

        // Randomized traffic with random backpressure, checked by the scoreboard.
        for (int i = 0; i < 600; i++) begin
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.in_data   = 16'($urandom);
            bus.rfread    = 16'($urandom);
            bus.in_mode   = 2'($urandom);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        cyc = 0;
        while ((exp_q.size() != 0 || bus.out_valid) && cyc < 50) begin
            step();
            cyc++;
        end
        if (cyc >= 50) fail("drain");
        else check("drain_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
